// File: rtl/dm_lsu.sv
// Load/store unit: single-outstanding request path from the MEM stage onto a
// word-addressed, byte-enabled synchronous RAM, with a valid/ready response.
module dm_lsu #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 3072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_en,
    output logic [3:0]        dm_we,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [3:0]  st_we;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)
            req_err = 1'b1;
        if (req_size == 2'd1 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        dm_din = req_wdata;
        st_we  = 4'b1111;
        case (req_size)
            2'd0: begin
                dm_din = {4{req_wdata[7:0]}};
                st_we  = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                dm_din = {2{req_wdata[15:0]}};
                st_we  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dm_din = req_wdata;
                st_we  = 4'b1111;
            end
        endcase
    end

    assign dm_addr = req_addr[ADDR_W+1:2];
    assign dm_en   = accept && !req_err;
    assign dm_we   = (dm_en && req_we) ? st_we : 4'b0000;

    always_comb begin
        case (off_q)
            2'd0:    lane_b = dm_dout[7:0];
            2'd1:    lane_b = dm_dout[15:8];
            2'd2:    lane_b = dm_dout[23:16];
            default: lane_b = dm_dout[31:24];
        endcase
        lane_h = off_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{!uns_q && lane_b[7]}}, lane_b};
            2'd1:    load_ext = {{16{!uns_q && lane_h[15]}}, lane_h};
            default: load_ext = dm_dout;
        endcase
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d    = req_rd;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err || req_we) begin
                        state_d = RESP;
                    end else begin
                        off_d   = req_addr[1:0];
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

endmodule
